// File: rtl/bram_port_requester.sv
// Request/response initiator for one port of a read-first BRAM.
// Tracks the fixed read latency and returns one in-order response per accepted request.
module bram_port_requester #(
    parameter int unsigned DATA_WIDTH   = 88,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned RESP_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_write,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_regce,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int unsigned OCC_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_DEPTH - 1);

    logic [OCC_W-1:0]        occ;
    logic [OCC_W-1:0]        count;
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_write;
    logic [DATA_WIDTH-1:0]   fifo_data [RESP_DEPTH];
    logic [RESP_DEPTH-1:0]   fifo_wr;
    logic                    accept;
    logic                    push;
    logic                    pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Slots are reserved at accept time, so the FIFO can never overflow.
    assign req_ready  = resetn && (occ < DEPTH_C) && !flush;
    assign accept     = req_valid && req_ready;
    assign bram_en    = accept;
    assign bram_we    = accept && req_write;
    assign bram_addr  = req_addr;
    assign bram_din   = req_wdata;

    assign push       = pipe_valid[READ_LATENCY-1] && !flush;
    assign resp_valid = (count != '0);
    assign pop        = resp_valid && resp_ready && !flush;
    assign resp_rdata = fifo_data[head];
    assign resp_write = fifo_wr[head];

    generate
        if (READ_LATENCY == 2) begin : g_regce
            assign bram_regce = pipe_valid[0];
        end else begin : g_no_regce
            assign bram_regce = 1'b0;
        end
    endgenerate

    // Latency-tracking shift register: one {valid, is_write} per BRAM pipeline stage.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pipe_valid <= '0;
            pipe_write <= '0;
        end else begin
            pipe_write[0] <= req_write;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_write[i] <= pipe_write[i-1];
            end
            if (flush) begin
                pipe_valid <= '0;
            end else begin
                pipe_valid[0] <= accept;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    pipe_valid[i] <= pipe_valid[i-1];
                end
            end
        end
    end

    // Pointers, buffered count and total occupancy; flush wins over push and pop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            occ   <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            occ   <= '0;
        end else begin
            if (push) begin
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
            case ({accept, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Response storage is plain data and deliberately not reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[tail] <= bram_dout;
            fifo_wr[tail]   <= pipe_write[READ_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_bram_port_requester.sv
// Bench for bram_port_requester: read-first BRAM models, a queue-based response
// model checked every cycle, and directed latency/backpressure/flush/reset scenarios.
module tb_bram_port_requester;

    localparam int unsigned DW    = 88;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 4;

    logic          clock;
    logic          resetn;
    logic          flush;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_ready, resp_write;
    logic [DW-1:0] resp_rdata;
    logic          bram_en, bram_we, bram_regce;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;

    logic          flush_l1;
    logic          req_valid_l1, req_ready_l1, req_write_l1;
    logic [AW-1:0] req_addr_l1;
    logic [DW-1:0] req_wdata_l1;
    logic          resp_valid_l1, resp_ready_l1, resp_write_l1;
    logic [DW-1:0] resp_rdata_l1;
    logic          bram_en_l1, bram_we_l1, bram_regce_l1;
    logic [AW-1:0] bram_addr_l1;
    logic [DW-1:0] bram_din_l1, bram_dout_l1;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc_n    = 0;

    bram_port_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .RESP_DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_write(resp_write),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_regce(bram_regce), .bram_dout(bram_dout)
    );

    bram_port_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RESP_DEPTH(DEPTH)) dut_l1 (
        .clock(clock), .resetn(resetn), .flush(flush_l1),
        .req_valid(req_valid_l1), .req_ready(req_ready_l1), .req_write(req_write_l1),
        .req_addr(req_addr_l1), .req_wdata(req_wdata_l1),
        .resp_valid(resp_valid_l1), .resp_ready(resp_ready_l1), .resp_rdata(resp_rdata_l1),
        .resp_write(resp_write_l1),
        .bram_en(bram_en_l1), .bram_we(bram_we_l1), .bram_addr(bram_addr_l1), .bram_din(bram_din_l1),
        .bram_regce(bram_regce_l1), .bram_dout(bram_dout_l1)
    );

    // Read-first BRAM models: HIGH_PERFORMANCE (output register) and LOW_LATENCY.
    logic [DW-1:0] mem    [1024];
    logic [DW-1:0] mem_l1 [1024];
    logic [DW-1:0] ram_q, dout_reg, ram_q_l1;

    always @(posedge clock) begin
        if (bram_en) begin
            ram_q <= mem[bram_addr];
            if (bram_we) mem[bram_addr] <= bram_din;
        end
        if (bram_regce) dout_reg <= ram_q;
    end
    assign bram_dout = dout_reg;

    always @(posedge clock) begin
        if (bram_en_l1) begin
            ram_q_l1 <= mem_l1[bram_addr_l1];
            if (bram_we_l1) mem_l1[bram_addr_l1] <= bram_din_l1;
        end
    end
    assign bram_dout_l1 = ram_q_l1;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc_n++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: every accepted request owes one response, due READ_LATENCY+1
    // cycles later, carrying the memory contents before that request.
    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] ref_mem [1024];
    int            occ_m    = 0;
    logic          prev_acc = 1'b0;
    logic          exp_rdy, exp_v, acc, pop;

    initial forever begin
        @(negedge clock);
        chk("l1_regce", 128'(bram_regce_l1), 128'(1'b0));
        if (!resetn) begin
            q.delete();
            occ_m    = 0;
            prev_acc = 1'b0;
            chk("rst_resp_valid", 128'(resp_valid), 128'(1'b0));
            chk("rst_bram_en", 128'(bram_en), 128'(1'b0));
            chk("rst_bram_we", 128'(bram_we), 128'(1'b0));
            chk("rst_regce", 128'(bram_regce), 128'(1'b0));
        end else begin
            exp_rdy = (occ_m < DEPTH) && !flush;
            chk("req_ready", 128'(req_ready), 128'(exp_rdy));
            chk("bram_en", 128'(bram_en), 128'(req_valid && exp_rdy));
            chk("bram_we", 128'(bram_we), 128'(req_valid && exp_rdy && req_write));
            if (bram_en) begin
                chk("bram_addr", 128'(bram_addr), 128'(req_addr));
                chk("bram_din", 128'(bram_din), 128'(req_wdata));
            end
            chk("bram_regce", 128'(bram_regce), 128'(prev_acc));
            exp_v = (q.size() != 0) && (q[0].due <= cyc_n);
            chk("resp_valid", 128'(resp_valid), 128'(exp_v));
            if (resp_valid && exp_v) begin
                chk("resp_write", 128'(resp_write), 128'(q[0].wr));
                chk("resp_rdata", 128'(resp_rdata), 128'(q[0].data));
            end
            acc = req_valid && req_ready;
            pop = resp_valid && resp_ready;
            if (flush) begin
                q.delete();
                occ_m = 0;
            end else begin
                if (pop && q.size() != 0) begin
                    void'(q.pop_front());
                    occ_m--;
                end
                if (acc) begin
                    q.push_back('{wr: req_write, data: ref_mem[req_addr], due: cyc_n + 3});
                    if (req_write) ref_mem[req_addr] = req_wdata;
                    occ_m++;
                end
            end
            prev_acc = acc;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) cyc();
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    logic [DW-1:0] wval;
    int            acc_cnt;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = '0;
            mem_l1[i]  = '0;
            ref_mem[i] = '0;
        end
        resetn = 1'b1;  flush = 1'b0;  flush_l1 = 1'b0;
        req_valid = 1'b0;  req_write = 1'b0;  req_addr = '0;  req_wdata = '0;
        req_valid_l1 = 1'b0;  req_write_l1 = 1'b0;  req_addr_l1 = '0;  req_wdata_l1 = '0;
        resp_ready = 1'b1;  resp_ready_l1 = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) cyc();
        resetn = 1'b1;
        at_neg();
        chk("post_rst_ready", 128'(req_ready), 128'(1'b1));
        chk("post_rst_rv", 128'(resp_valid), 128'(1'b0));

        // Write A=5 then read A=5 on both latency builds.
        cyc();
        req_valid = 1'b1;  req_write = 1'b1;  req_addr = 10'd5;  req_wdata = 88'h1234;
        req_valid_l1 = 1'b1;  req_write_l1 = 1'b1;  req_addr_l1 = 10'd5;  req_wdata_l1 = 88'h1234;
        at_neg();
        chk("s1_we", 128'(bram_we), 128'(1'b1));
        chk("l1_we", 128'(bram_we_l1), 128'(1'b1));
        cyc();
        req_write = 1'b0;  req_write_l1 = 1'b0;
        at_neg();
        chk("s1_regce_t1", 128'(bram_regce), 128'(1'b1));
        chk("s1_rv_t1", 128'(resp_valid), 128'(1'b0));
        chk("l1_rv_t1", 128'(resp_valid_l1), 128'(1'b0));
        cyc();
        req_valid = 1'b0;  req_valid_l1 = 1'b0;
        at_neg();
        chk("s1_rv_t2", 128'(resp_valid), 128'(1'b0));
        chk("l1_rv_t2", 128'(resp_valid_l1), 128'(1'b1));
        chk("l1_wr_t2", 128'(resp_write_l1), 128'(1'b1));
        chk("l1_data_t2", 128'(resp_rdata_l1), 128'(0));
        cyc();
        at_neg();
        chk("s1_rv_t3", 128'(resp_valid), 128'(1'b1));
        chk("s1_wr_t3", 128'(resp_write), 128'(1'b1));
        chk("s1_data_t3", 128'(resp_rdata), 128'(0));
        chk("l1_rv_t3", 128'(resp_valid_l1), 128'(1'b1));
        chk("l1_wr_t3", 128'(resp_write_l1), 128'(1'b0));
        chk("l1_data_t3", 128'(resp_rdata_l1), 128'(88'h1234));
        cyc();
        at_neg();
        chk("s1_rv_t4", 128'(resp_valid), 128'(1'b1));
        chk("s1_wr_t4", 128'(resp_write), 128'(1'b0));
        chk("s1_data_t4", 128'(resp_rdata), 128'(88'h1234));
        idle(3);

        // Streaming: 16 back-to-back reads.
        for (int k = 0; k < 20; k++) begin
            cyc();
            req_valid = (k < 16);
            req_write = 1'b0;
            req_addr  = AW'($urandom_range(0, 1023));
            at_neg();
            if (k < 16) chk("stream_ready", 128'(req_ready), 128'(1'b1));
            if (k >= 3 && k < 19) chk("stream_rv", 128'(resp_valid), 128'(1'b1));
            if (k == 19) chk("stream_end", 128'(resp_valid), 128'(1'b0));
        end
        idle(4);

        // Backpressure: only DEPTH requests may be accepted.
        resp_ready = 1'b0;
        acc_cnt    = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            req_valid = 1'b1;
            req_write = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 7));
            req_wdata = rand_data();
            at_neg();
            if (req_valid && req_ready) acc_cnt++;
        end
        chk("bp_accepted", 128'(acc_cnt), 128'(DEPTH));
        chk("bp_ready_low", 128'(req_ready), 128'(1'b0));
        chk("bp_en_low", 128'(bram_en), 128'(1'b0));
        cyc();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        at_neg();
        chk("bp_rv_d0", 128'(resp_valid), 128'(1'b1));
        chk("bp_ready_d0", 128'(req_ready), 128'(1'b0));
        cyc();
        at_neg();
        chk("bp_ready_d1", 128'(req_ready), 128'(1'b1));
        chk("bp_rv_d1", 128'(resp_valid), 128'(1'b1));
        cyc();
        at_neg();
        chk("bp_rv_d2", 128'(resp_valid), 128'(1'b1));
        cyc();
        at_neg();
        chk("bp_rv_d3", 128'(resp_valid), 128'(1'b1));
        cyc();
        at_neg();
        chk("bp_rv_d4", 128'(resp_valid), 128'(1'b0));
        idle(3);

        // Flush with one response buffered and two requests in flight (newest is a write).
        resp_ready = 1'b0;
        wval       = rand_data();
        cyc();
        req_valid = 1'b1;  req_write = 1'b0;  req_addr = 10'd30;
        cyc();
        req_addr = 10'd31;
        cyc();
        req_write = 1'b1;  req_addr = 10'd20;  req_wdata = wval;
        cyc();
        flush = 1'b1;  req_write = 1'b0;  req_addr = 10'd21;
        at_neg();
        chk("fl_ready", 128'(req_ready), 128'(1'b0));
        chk("fl_en", 128'(bram_en), 128'(1'b0));
        chk("fl_rv_buffered", 128'(resp_valid), 128'(1'b1));
        cyc();
        flush = 1'b0;  req_valid = 1'b0;
        at_neg();
        chk("fl_rv_after", 128'(resp_valid), 128'(1'b0));
        chk("fl_ready_after", 128'(req_ready), 128'(1'b1));
        for (int k = 0; k < 4; k++) begin
            cyc();
            at_neg();
            chk("fl_rv_quiet", 128'(resp_valid), 128'(1'b0));
        end
        resp_ready = 1'b1;
        cyc();
        req_valid = 1'b1;  req_write = 1'b0;  req_addr = 10'd20;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        at_neg();
        chk("fl_read_rv", 128'(resp_valid), 128'(1'b1));
        chk("fl_read_wr", 128'(resp_write), 128'(1'b0));
        chk("fl_read_data", 128'(resp_rdata), 128'(wval));
        idle(3);

        // Asynchronous reset mid-cycle with responses pending.
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            req_valid = 1'b1;  req_write = 1'b0;
            req_addr  = AW'($urandom_range(0, 7));
        end
        #1;
        chk("ar_rv_pre", 128'(resp_valid), 128'(1'b1));
        chk("ar_en_pre", 128'(bram_en), 128'(1'b1));
        #1 resetn = 1'b0;
        #1;
        chk("ar_rv_async", 128'(resp_valid), 128'(1'b0));
        chk("ar_en_async", 128'(bram_en), 128'(1'b0));
        req_valid = 1'b0;
        #3 resetn = 1'b1;
        resp_ready = 1'b1;
        cyc();
        req_valid = 1'b1;  req_write = 1'b0;  req_addr = 10'd20;
        at_neg();
        chk("ar_new_en", 128'(bram_en), 128'(1'b1));
        cyc();
        req_valid = 1'b0;
        at_neg();
        chk("ar_new_rv_t1", 128'(resp_valid), 128'(1'b0));
        cyc();
        at_neg();
        chk("ar_new_rv_t2", 128'(resp_valid), 128'(1'b0));
        cyc();
        at_neg();
        chk("ar_new_rv_t3", 128'(resp_valid), 128'(1'b1));
        chk("ar_new_data", 128'(resp_rdata), 128'(wval));
        idle(2);

        // Random traffic over a small address range, with occasional flushes.
        for (int k = 0; k < 400; k++) begin
            cyc();
            req_valid  = ($urandom_range(0, 3) != 0);
            req_write  = 1'($urandom_range(0, 1));
            req_addr   = AW'($urandom_range(0, 7));
            req_wdata  = rand_data();
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
        end
        cyc();
        flush      = 1'b0;
        resp_ready = 1'b1;
        idle(10);
        at_neg();
        chk("final_empty", 128'(resp_valid), 128'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_port_requester.md
# bram_port_requester

Initiator for one port of the team's true dual-port read-first BRAM. Turns an in-order valid/ready request stream (read or write) into BRAM port controls, tracks the fixed read latency and returns exactly one in-order response per request. Because the BRAM is read-first, a write's response carries the prior contents at that address. Sits between a cache/predictor pipeline stage and a BRAM port.

## Interface
- DATA_WIDTH, 88, data width; matches the BRAM RAM_WIDTH.
- ADDR_WIDTH, 10, address width; clog2 of the BRAM depth.
- READ_LATENCY, 2, BRAM read latency:
  - 1 means the BRAM is in LOW_LATENCY mode.
  - 2 means the BRAM is in HIGH_PERFORMANCE mode.
  - Any other value is illegal.
- RESP_DEPTH, 4, response buffer entries; must be at least 2. RESP_DEPTH >= READ_LATENCY+2 gives full throughput.
- clock  in  1  single clock; drives the BRAM clock as well.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all in-flight and buffered responses.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_rdata  out  DATA_WIDTH  read data, or old contents for a write.
- resp_write  out  1  the response belongs to a write.
- bram_en  out  1  BRAM port enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_din  out  DATA_WIDTH  BRAM write data.
- bram_regce  out  1  BRAM output-register enable; driven 0 when READ_LATENCY=1.
- bram_dout  in  DATA_WIDTH  BRAM read data.

## Operation
- **Issue (combinational):**
  - bram_en = req_valid && req_ready.
  - bram_we = bram_en && req_write.
  - bram_addr and bram_din are passed through from req_addr and req_wdata.
  - With bram_en low, bram_we is 0. bram_addr and bram_din are don't-care.
- **Tracking pipeline:** READ_LATENCY stages, each holding {valid, is_write}.
  - Stage 0 loads {bram_en, req_write} every cycle.
  - Each later stage shifts from the previous stage.
  - bram_regce = stage-0 valid when READ_LATENCY=2.
- **Response FIFO:** RESP_DEPTH entries of {is_write, data}, with head/tail pointers and a count.
  - When the last pipeline stage is valid, {is_write, bram_dout} is written at that clock edge.
  - Pointers wrap modulo RESP_DEPTH; RESP_DEPTH need not be a power of two.
  - resp_valid = (count != 0). resp_rdata and resp_write come from the head entry and are registered storage, not bram_dout.
- **Occupancy counter:** width clog2(RESP_DEPTH+1).
  - +1 on each accepted request, -1 on each popped response. Accept and pop in the same cycle leave it unchanged.
  - req_ready = (occupancy < RESP_DEPTH) && !flush.
  - There is no combinational path from resp_ready to req_ready.
  - Because slots are reserved at accept time, the FIFO can never overflow and bram_dout is never dropped.
- **Flush:**
  - In the flush cycle: req_ready is 0, so no issue occurs.
  - At the flush edge: pipeline valids, FIFO pointers, count and occupancy all clear. A pop in that cycle is ignored; flush wins.
  - Writes already issued to the BRAM still take effect. Only their responses are discarded.
- **Reset (resetn low, asynchronous):**
  - Clears pipeline valids, pointers, count and occupancy.
  - Outputs during and after reset: resp_valid=0, bram_en=0, bram_we=0, bram_regce=0.
  - req_ready=1 after reset unless flush is high.
  - FIFO data storage is not reset.
  - Reset mid-operation discards everything in flight; the BRAM contents are undefined only for a write that reset interrupts in the same cycle.
- **Ordering:** responses leave in strict request order.

## Timing
- A request accepted in cycle t produces resp_valid in cycle t+READ_LATENCY+1, provided the FIFO is empty.
- bram_regce is high in cycle t+1 (READ_LATENCY=2).
- Throughput is 1 request/cycle when RESP_DEPTH >= READ_LATENCY+2 and resp_ready stays high. Smaller depths throttle to RESP_DEPTH requests per READ_LATENCY+2 cycles.
- Backpressure: with resp_ready low, at most RESP_DEPTH requests are accepted; then req_ready drops.
  - req_ready rises in the cycle after the first pop.
- Read-first hazard: a write to A at t followed by a read of A at t+1 returns the new data, because the BRAM applied the write at the edge ending cycle t. The write's own response returns the old data.

## Test plan
- **Reset and write/read:**
  - Stimulus: reset, then write A=5 with 0x1234, then read A=5, with resp_ready=1 and READ_LATENCY=2.
  - Required: write response (resp_write=1) returns 0 in cycle t+3; read response returns 0x1234 in cycle t+4.
- **Streaming:**
  - Stimulus: 16 back-to-back reads with RESP_DEPTH=4 and resp_ready=1.
  - Required: req_ready stays 1; 16 responses arrive on consecutive cycles, in order.
- **Backpressure:**
  - Stimulus: hold resp_ready=0 while req_valid=1.
  - Required: exactly 4 requests are accepted, then req_ready=0 and bram_en=0.
  - Then raise resp_ready: all 4 responses drain in order and req_ready returns to 1 one cycle after the first pop.
- **Flush:**
  - Stimulus: assert flush with 2 requests in the pipeline and 1 response buffered.
  - Required: req_ready=0 in the flush cycle, resp_valid=0 in the next cycle, occupancy=0.
  - A later read of an address written before the flush returns the written value.
- **Asynchronous reset:**
  - Stimulus: pulse resetn low mid-clock while responses are pending.
  - Required: resp_valid and bram_en fall immediately, without waiting for a clock edge; the first new request after release is served with normal latency.
- **READ_LATENCY=1 build:**
  - Stimulus: run the write/read scenario in a READ_LATENCY=1 build.
  - Required: responses arrive in cycle t+2, and bram_regce stays 0.
